// File: rtl/div_32_11_pkg.sv
// Shared constants and types for the divide-by-11 family and its inverse.
// Holds the constant divisor, the operand widths, the largest quotient that
// cannot overflow XW bits, and the stage-1 payload of mul_32_11_recon.
package div_32_11_pkg;

  localparam int D_CONST = 11;
  localparam int XW      = 32;
  localparam int QW      = 29;
  localparam int RW      = 4;
  localparam int CW      = 8;

  // floor((2^XW-1)/D): any larger quotient overflows for every legal remainder
  localparam logic [XW-1:0] QMAX = 32'd390451572;

  typedef struct packed {
    logic [XW+1:0] a;     // (D-1)*Q as shift-adds
    logic [QW-1:0] q;
    logic [RW-1:0] r;
    logic          rerr;  // R >= D
  } s1_t;

endpackage

// File: rtl/mul_const_add.sv
// Combinational D*Q+R expansion, split in two halves around the stage-1
// register of mul_32_11_recon.
//   q, r        : raw quotient/remainder (input side of stage 1)
//   a           : (D-1)*Q built from shifted copies of Q
//   s_a/s_q/s_r : registered stage-1 values
//   sum         : s_a + s_q + s_r at full XW+2 width (no truncation)
module mul_const_add #(
  parameter int D  = 11,
  parameter int XW = 32,
  parameter int QW = 29,
  parameter int RW = 4
) (
  input  logic [QW-1:0] q,
  input  logic [RW-1:0] r,
  output logic [XW+1:0] a,
  input  logic [XW+1:0] s_a,
  input  logic [QW-1:0] s_q,
  input  logic [RW-1:0] s_r,
  output logic [XW+1:0] sum
);

  logic [XW+1:0] q_ext;
  logic [XW+1:0] sq_ext;
  logic [XW+1:0] sr_ext;

  assign q_ext  = {{(XW+2-QW){1'b0}}, q};
  assign sq_ext = {{(XW+2-QW){1'b0}}, s_q};
  assign sr_ext = {{(XW+2-RW){1'b0}}, s_r};

  // D is odd, so D*Q = (D-1)*Q + Q; the (D-1) part is one shifted copy of Q
  // per set bit of the even constant D-1 (for D=11: Q<<3 + Q<<1).
  always_comb begin
    a = '0;
    for (int k = 0; k < XW + 2; k++) begin
      if (((D - 1) >> k) % 2 == 1) a = a + (q_ext << k);
    end
  end

  assign sum = s_a + sq_ext + sr_ext;

endmodule

// File: rtl/mul_32_11_recon.sv
// Rebuilds the dividend X = D*Q + R from a quotient/remainder pair.
// Two-stage elastic pipeline with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for Q, R
//   out_valid/out_ready : output handshake for X, r_err, ovf
//   X                   : low XW bits of D*Q+R
//   r_err               : R >= D for this result
//   ovf                 : D*Q+R >= 2^XW for this result
//   err_cnt             : saturating count of results with r_err or ovf
module mul_32_11_recon #(
  parameter int D  = div_32_11_pkg::D_CONST,
  parameter int XW = div_32_11_pkg::XW,
  parameter int QW = div_32_11_pkg::QW,
  parameter int RW = div_32_11_pkg::RW,
  parameter int CW = div_32_11_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] Q,
  input  logic [RW-1:0] R,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] X,
  output logic          r_err,
  output logic          ovf,
  output logic [CW-1:0] err_cnt
);

  import div_32_11_pkg::*;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  s1_t           s1_p1;
  s1_t           s1_d;
  logic          s1_valid;
  logic          s2_valid;
  logic [XW+1:0] a_w;
  logic [XW+1:0] sum_w;
  logic          s2_adv;
  logic          s1_adv;
  logic          in_xfer;
  logic          ovf_w;

  mul_const_add #(
    .D  (D),
    .XW (XW),
    .QW (QW),
    .RW (RW)
  ) u_mca (
    .q   (Q),
    .r   (R),
    .a   (a_w),
    .s_a (s1_p1.a),
    .s_q (s1_p1.q),
    .s_r (s1_p1.r),
    .sum (sum_w)
  );

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // Combinational from out_ready so a full pipeline can still stream.
  assign in_ready = !s1_valid || s2_adv;
  assign in_xfer  = in_valid && in_ready;

  assign s1_d.a    = a_w;
  assign s1_d.q    = Q;
  assign s1_d.r    = R;
  assign s1_d.rerr = (R >= RW'(D));

  assign ovf_w     = |sum_w[XW+1:XW];
  assign out_valid = s2_valid;

  // Stage 0 -> 1: payload register, no reset needed (qualified by s1_valid)
  always_ff @(posedge clk) begin
    if (in_xfer) s1_p1 <= s1_d;
  end

  // Stage 1 -> 2: control, result registers and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      X        <= '0;
      r_err    <= 1'b0;
      ovf      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv)   s2_valid <= s1_valid;
      if (s1_adv) begin
        X     <= sum_w[XW-1:0];
        ovf   <= ovf_w;
        r_err <= s1_p1.rerr;
        if (s1_p1.rerr || ovf_w) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mul_32_11_recon.sv
// Directed bench for mul_32_11_recon: reset, streaming, flag boundaries,
// backpressure ordering, random loopback and counter saturation.
module tb_mul_32_11_recon;

  import div_32_11_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] Q;
  logic [RW-1:0] R;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] X;
  logic          r_err;
  logic          ovf;
  logic [CW-1:0] err_cnt;

  typedef struct {
    logic [31:0] x;
    logic        re;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_out   = 0;
  bit   mon_en  = 1'b0;

  mul_32_11_recon dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .r_err     (r_err),
    .ovf       (ovf),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Output scoreboard: every output transfer must match the oldest accepted pair.
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("x", 64'(X), 64'(e.x));
        chk("r_err", 64'(r_err), 64'(e.re));
        chk("ovf", 64'(ovf), 64'(e.ov));
      end
      n_out++;
    end
  end

  task automatic send(input logic [QW-1:0] q, input logic [RW-1:0] r,
                      input logic [31:0] ex, input logic ere, input logic eov);
    bit done;
    done = 1'b0;
    Q = q;
    R = r;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_t e;
        e.x = ex;
        e.re = ere;
        e.ov = eov;
        exp_q.push_back(e);
        n_acc++;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base_acc;
    int base_out;
    logic [31:0] x;
    logic [31:0] qq;
    logic [31:0] rr;
    logic [31:0] t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; Q = '0; R = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));

    // Mid-stream reset with in_valid held
    rst = 1'b0;
    Q = 29'd5; R = 4'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    Q = 29'd7; R = 4'd2;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_x", 64'(X), 64'(67));
    chk("pre_rst_rerr", 64'(r_err), 64'(1));
    chk("pre_rst_cnt", 64'(err_cnt), 64'(1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("in_rst_valid", 64'(out_valid), 64'(0));
      chk("in_rst_cnt", 64'(err_cnt), 64'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("post_rst_lat2", 64'(out_valid), 64'(1));
    chk("post_rst_x", 64'(X), 64'(79));
    chk("post_rst_flags", 64'({r_err, ovf}), 64'(0));
    chk("post_rst_cnt", 64'(err_cnt), 64'(0));
    @(posedge clk); #1;
    chk("post_rst_drained", 64'(out_valid), 64'(0));
    mon_en = 1'b1;

    // Streaming, legal pairs including the maximum legal pair
    send(QW'(QMAX), 4'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(29'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    send(29'd1234, 4'd10, 32'd13584, 1'b0, 1'b0);
    drain();
    chk("stream_cnt", 64'(err_cnt), 64'(0));

    // Illegal remainder
    send(29'd5, 4'd11, 32'd66, 1'b1, 1'b0);
    drain();
    chk("rerr_cnt", 64'(err_cnt), 64'(1));

    // Overflow, then both flags at once, then just above QMAX
    send(29'd390451572, 4'd4, 32'd0, 1'b0, 1'b1);
    send(29'h1FFF_FFFF, 4'd15, 32'h6000_0004, 1'b1, 1'b1);
    drain();
    chk("ovf_cnt", 64'(err_cnt), 64'(3));
    send(29'd390451573, 4'd0, 32'd7, 1'b0, 1'b1);
    drain();
    chk("ovf_cnt2", 64'(err_cnt), 64'(4));

    // Backpressure
    base_acc = n_acc;
    base_out = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(29'd10, 4'd1, 32'd111, 1'b0, 1'b0);
        send(29'd20, 4'd2, 32'd222, 1'b0, 1'b0);
        send(29'd30, 4'd3, 32'd333, 1'b0, 1'b0);
        send(29'd40, 4'd4, 32'd444, 1'b0, 1'b0);
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepted", 64'(n_acc - base_acc), 64'(2));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_x_hold", 64'(X), 64'(111));
    @(posedge clk); #1;
    chk("bp_x_stable", 64'(X), 64'(111));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_stall2_valid", 64'(out_valid), 64'(1));
    chk("bp_stall2_x", 64'(X), 64'(222));
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_out_count", 64'(n_out - base_out), 64'(4));

    // Random loopback through a reference divider
    for (int i = 0; i < 10000; i++) begin
      x  = $urandom;
      qq = x / 32'd11;
      rr = x % 32'd11;
      send(qq[QW-1:0], rr[RW-1:0], x, 1'b0, 1'b0);
    end
    drain();
    chk("loop_cnt", 64'(err_cnt), 64'(4));

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      t = 32'(11 * i + 12);
      send(QW'(i), 4'd12, t, 1'b1, 1'b0);
    end
    drain();
    chk("sat_cnt", 64'(err_cnt), 64'(255));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
